btn_debounce: RTL and testbench

Multi-channel push-button conditioner that replaces the single-channel edge filter on the board inputs. Each channel has a two-flop synchroniser, a counter-based debouncer, registered press/release pulses and an optional auto-repeat. The block sits between the raw board buttons and the calculator input/FSM logic. All outputs are glitch-free and synchronous to `clk`.

---
 rtl/btn_debounce.sv | 109 ++++++++++
 tb/tb_btn_debounce.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: per-channel two-flop synchroniser,
// counter debouncer, registered press/release pulses and optional auto-repeat.

module btn_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic lift
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rp_cnt;
  logic          steady;
  logic          accept;
  logic          rp_hit;

  assign accept = (s2 != level) && (db_cnt == DB_LAST);
  assign rp_hit = steady ? (rp_cnt == RATE_LAST) : (rp_cnt == DLY_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      lift   <= 1'b0;
      rp_cnt <= '0;
      steady <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      lift  <= 1'b0;

      // any single cycle of agreement restarts the count
      if (s2 == level)
        db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        level  <= s2;
      end else
        db_cnt <= db_cnt + 1'b1;

      // accepted edges win over a repeat that would land on the same cycle
      if (accept && s2) begin
        press  <= 1'b1;
        rp_cnt <= '0;
        steady <= 1'b0;
      end else if (accept) begin
        lift   <= 1'b1;
        rp_cnt <= '0;
        steady <= 1'b0;
      end else if ((REPEAT_EN != 0) && level) begin
        if (rp_hit) begin
          press  <= 1'b1;
          rp_cnt <= '0;
          steady <= 1'b1;
        end else
          rp_cnt <= rp_cnt + 1'b1;
      end
    end
  end
endmodule

module btn_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .lift (btn_release[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: two instances (repeat on / off) share the
// button inputs; expected values are hand-derived edge counts.

module tb_btn_debounce;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] lvl_a, prs_a, rel_a;
  logic [1:0] lvl_b, prs_b, rel_b;
  int errors = 0;
  int checks = 0;
  logic [1:0] ep, er;

  always #5 clk = ~clk;

  btn_debounce #(.N_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                 .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a));

  btn_debounce #(.N_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                 .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_nr (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b00;
    step(3);
    chk("reset_a", {lvl_a, prs_a, rel_a}, 0);
    chk("reset_b", {lvl_b, prs_b, rel_b}, 0);
    rst = 1'b0;

    // clean press / release on channel 0
    btn = 2'b01;
    step(5);
    chk("clean_lvl_e5", lvl_a, 2'b00);
    chk("clean_prs_e5", prs_a, 2'b00);
    step(1);
    chk("clean_lvl_e6", lvl_a, 2'b01);
    chk("clean_prs_e6", prs_a, 2'b01);
    chk("clean_rel_e6", rel_a, 2'b00);
    chk("nr_prs_e6", prs_b, 2'b01);
    step(1);
    chk("clean_prs_e7", prs_a, 2'b00);
    step(2);
    btn = 2'b00;
    step(5);
    chk("clean_lvl_held", lvl_a, 2'b01);
    chk("clean_prs_held", prs_a, 2'b00);
    step(1);
    chk("clean_lvl_rel", lvl_a, 2'b00);
    chk("clean_rel", rel_a, 2'b01);
    chk("clean_prs_rel", prs_a, 2'b00);
    chk("nr_rel", rel_b, 2'b01);
    step(1);
    chk("clean_rel_end", rel_a, 2'b00);

    // glitch: 3 cycles high is one short of acceptance
    btn = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 3) btn = 2'b00;
      chk("glitch", {lvl_a, prs_a, rel_a}, 0);
    end

    // bounce: 2-cycle toggles, then a stable high
    for (int seg = 0; seg < 6; seg++) begin
      btn = (seg % 2 == 0) ? 2'b01 : 2'b00;
      for (int j = 0; j < 2; j++) begin
        step(1);
        chk("bounce_quiet", {lvl_a, prs_a}, 0);
      end
    end
    btn = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("bounce_prs", prs_a, (i == 6) ? 2'b01 : 2'b00);
      chk("bounce_lvl", lvl_a, (i == 6) ? 2'b01 : 2'b00);
    end
    btn = 2'b00;
    step(6);
    chk("bounce_rel", rel_a, 2'b01);

    // auto-repeat; release timed so it lands on a repeat slot (t+19)
    btn = 2'b01;
    step(6);
    chk("rpt_t", prs_a, 2'b01);
    chk("nr_t", prs_b, 2'b01);
    for (int k = 1; k <= 25; k++) begin
      step(1);
      ep = (k == 10 || k == 13 || k == 16) ? 2'b01 : 2'b00;
      er = (k == 19) ? 2'b01 : 2'b00;
      chk("rpt_prs", prs_a, ep);
      chk("rpt_rel", rel_a, er);
      chk("nr_prs", prs_b, 2'b00);
      chk("nr_rel", rel_b, er);
      if (k == 13) btn = 2'b00;
    end
    chk("rpt_lvl_end", lvl_a, 2'b00);

    // channels pressed 2 cycles apart; ch1 released during ch0 repeat
    btn = 2'b01;
    step(2);
    btn = 2'b11;
    step(4);
    chk("ind_prs0", prs_a, 2'b01);
    for (int k = 1; k <= 22; k++) begin
      step(1);
      ep[0] = (k == 10 || k == 13 || k == 16 || k == 19 || k == 22);
      ep[1] = (k == 2 || k == 12);
      er    = (k == 14) ? 2'b10 : 2'b00;
      chk("ind_prs", prs_a, ep);
      chk("ind_rel", rel_a, er);
      if (k == 8) btn = 2'b01;
    end
    btn = 2'b00;
    step(6);
    chk("ind_rel0", rel_a, 2'b01);
    chk("ind_prs_rel0", prs_a, 2'b00);

    // simultaneous press and release
    btn = 2'b11;
    step(6);
    chk("sim_prs", prs_a, 2'b11);
    btn = 2'b00;
    step(6);
    chk("sim_rel", rel_a, 2'b11);
    chk("sim_lvl", lvl_a, 2'b00);

    // reset mid-debounce (count=2) then mid-repeat
    btn = 2'b01;
    step(4);
    rst = 1'b1;
    step(1);
    chk("rst_db", {lvl_a, prs_a, rel_a}, 0);
    rst = 1'b0;
    step(5);
    chk("rst_db_lvl5", lvl_a, 2'b00);
    step(1);
    chk("rst_db_prs6", prs_a, 2'b01);
    step(5);
    rst = 1'b1;
    step(1);
    chk("rst_rp", {lvl_a, prs_a, rel_a}, 0);
    rst = 1'b0;
    step(5);
    chk("rst_rp_5", {lvl_a, prs_a}, 0);
    step(1);
    chk("rst_rp_prs6", prs_a, 2'b01);
    step(9);
    chk("rst_rp_gap", prs_a, 2'b00);
    step(1);
    chk("rst_rp_rpt", prs_a, 2'b01);
    btn = 2'b00;
    step(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
